// File: rtl/v_alu_seq.sv
// rtl/v_alu_seq.sv - Chunked vector ALU sequencer that steps a wide vector through a narrow VALU
//
// Purpose: accepts one vector operation, presents it to the VALU one VALU_OP_W_MAX-bit
// chunk at a time and assembles the per-chunk results into vd. Each chunk takes two
// cycles (ISSUE, CAPTURE) so that the VALU's registered result is ready at capture.
//
// Optional feature macro: VALU_SEQ_MASK_EN (adds vm and vd_old, per-element masking).
//
// Ports:
//   clk, nrst                   clock, asynchronous active-low reset
//   start_valid / start_ready   request handshake (ready only in IDLE)
//   op_instr, vsew              opcode and element width, latched at acceptance
//   vs1, vs2                    source vectors, latched at acceptance
//   vm, vd_old                  (mask build only) element mask and old destination
//   alu_op_A, alu_op_B          current vs1 / vs2 chunk presented to the VALU
//   alu_op_instr, alu_vsew      latched opcode and element width to the VALU
//   alu_result                  VALU result for the current chunk
//   done_valid / done_ready     result handshake; vd held stable while done_valid
//   vd                          assembled result vector
//   busy                        sequencer is not idle

module v_alu_seq #(
  parameter int VECTOR_LENGTH = 128,
  parameter int VALU_OP_W_MAX = 32
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [3:0]                 op_instr,
  input  logic [1:0]                 vsew,
  input  logic [VECTOR_LENGTH-1:0]   vs1,
  input  logic [VECTOR_LENGTH-1:0]   vs2,
`ifdef VALU_SEQ_MASK_EN
  input  logic [VECTOR_LENGTH/8-1:0] vm,
  input  logic [VECTOR_LENGTH-1:0]   vd_old,
`endif
  output logic [VALU_OP_W_MAX-1:0]   alu_op_A,
  output logic [VALU_OP_W_MAX-1:0]   alu_op_B,
  output logic [3:0]                 alu_op_instr,
  output logic [1:0]                 alu_vsew,
  input  logic [VALU_OP_W_MAX-1:0]   alu_result,
  output logic                       done_valid,
  input  logic                       done_ready,
  output logic [VECTOR_LENGTH-1:0]   vd,
  output logic                       busy
);

  localparam int NCHUNK = VECTOR_LENGTH / VALU_OP_W_MAX;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t                     state;
  logic [KW-1:0]              k;
  logic [KW-1:0]              k_next;
  logic [VECTOR_LENGTH-1:0]   vs1_q;
  logic [VECTOR_LENGTH-1:0]   vs2_q;
  logic [VALU_OP_W_MAX-1:0]   cap_data;

  assign start_ready = (state == IDLE);
  assign k_next      = k + KW'(1);

`ifdef VALU_SEQ_MASK_EN
  localparam int CB = VALU_OP_W_MAX / 8;  // bytes per chunk

  logic [VECTOR_LENGTH/8-1:0] vm_q;
  logic [VECTOR_LENGTH-1:0]   vd_old_q;
  logic [CB-1:0]              en8;
  logic [CB/2-1:0]            en16;
  logic [CB/4-1:0]            en32;
  logic [CB-1:0]              be;
  logic [VALU_OP_W_MAX-1:0]   old_chunk;

  // Mask bits belonging to chunk k, one bit per element of the latched width.
  assign en8       = CB'(vm_q >> (k * CB));
  assign en16      = (CB/2)'(vm_q >> (k * (CB/2)));
  assign en32      = (CB/4)'(vm_q >> (k * (CB/4)));
  assign old_chunk = vd_old_q[k*VALU_OP_W_MAX +: VALU_OP_W_MAX];

  // Expand element enables to byte enables, then merge result with the old value.
  for (genvar b = 0; b < CB; b++) begin : g_byte
    assign be[b] = (alu_vsew == 2'd0) ? en8[b] :
                   (alu_vsew == 2'd1) ? en16[b/2] : en32[b/4];
    assign cap_data[b*8 +: 8] = be[b] ? alu_result[b*8 +: 8] : old_chunk[b*8 +: 8];
  end
`else
  assign cap_data = alu_result;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      k            <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      vd           <= '0;
      done_valid   <= 1'b0;
      busy         <= 1'b0;
      alu_op_A     <= '0;
      alu_op_B     <= '0;
      alu_op_instr <= '0;
      alu_vsew     <= '0;
`ifdef VALU_SEQ_MASK_EN
      vm_q         <= '0;
      vd_old_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            vs1_q        <= vs1;
            vs2_q        <= vs2;
            alu_op_instr <= op_instr;
            alu_vsew     <= vsew;
`ifdef VALU_SEQ_MASK_EN
            vm_q         <= vm;
            vd_old_q     <= vd_old;
`endif
            vd           <= '0;
            k            <= '0;
            // Operands come straight from the inputs so chunk 0 is valid in ISSUE.
            alu_op_A     <= vs1[VALU_OP_W_MAX-1:0];
            alu_op_B     <= vs2[VALU_OP_W_MAX-1:0];
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          vd[k*VALU_OP_W_MAX +: VALU_OP_W_MAX] <= cap_data;
          if (k == K_LAST) begin
            alu_op_A   <= '0;
            alu_op_B   <= '0;
            done_valid <= 1'b1;
            state      <= DONE;
          end else begin
            k        <= k_next;
            alu_op_A <= vs1_q[k_next*VALU_OP_W_MAX +: VALU_OP_W_MAX];
            alu_op_B <= vs2_q[k_next*VALU_OP_W_MAX +: VALU_OP_W_MAX];
            state    <= ISSUE;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
